// File: rtl/challenge_pkg.sv
// Shared definitions for the OBC challenge-response watchdog:
// state encoding, default LFSR constants and the expected-answer encoding.
package challenge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_DONE    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  localparam int         MAX_WIDTH    = 32;
  localparam logic [3:0] DEFAULT_POLY = 4'hC;
  localparam logic [3:0] DEFAULT_SEED = 4'h1;

  // Bit i of the answer depends only on question bits 0..i, so callers may
  // truncate the result to their own width.
  function automatic logic [MAX_WIDTH-1:0] expected_answer(input logic [MAX_WIDTH-1:0] q);
    logic [MAX_WIDTH-1:0] e;
    e[0] = ~q[0];
    for (int i = 1; i < MAX_WIDTH; i++) begin
      e[i] = q[i-1] ^ q[i];
    end
    return e;
  endfunction

endpackage

// File: rtl/challenge_lfsr.sv
// Galois LFSR question source; steps once per completed round and keeps its
// value across sessions (only reset reloads SEED).
module challenge_lfsr
  import challenge_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             advance,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] next_s;

  // Galois step: shift right, fold in the feedback mask when bit 0 drops out
  always_comb begin
    next_s = q >> 1;
    if (q[0]) begin
      next_s = (q >> 1) ^ POLY;
    end else begin
      next_s = q >> 1;
    end
  end

  // LFSR state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= SEED;
    end else if (advance) begin
      q <= next_s;
    end
  end

endmodule

// File: rtl/challenge_watchdog.sv
// Challenge-response watchdog: asks LFSR questions, times out silent answers,
// counts passes/faults per session and latches override on too many faults.
module challenge_watchdog
  import challenge_pkg::*;
#(
  parameter int               WIDTH      = 4,
  parameter int               ROUNDS     = 10,
  parameter int               TIMEOUT    = 8,
  parameter int               MAX_FAULTS = 3,
  parameter logic [WIDTH-1:0] POLY       = WIDTH'(DEFAULT_POLY),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEFAULT_SEED),
  localparam int              PW         = $clog2(ROUNDS + 1),
  localparam int              FW         = $clog2(MAX_FAULTS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [WIDTH-1:0] question,
  output logic             question_valid,
  input  logic [WIDTH-1:0] answer,
  input  logic             answer_valid,
  output logic             busy,
  output logic             done,
  output logic             override,
  output logic [PW-1:0]    pass_count,
  output logic [FW-1:0]    fault_count
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [PW-1:0] ROUNDS_P   = PW'(ROUNDS);
  localparam logic [FW-1:0] FAULT_MAX  = FW'(MAX_FAULTS);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  state_t           state_r, next_state_s;
  logic [TW-1:0]    timer_r;
  logic [PW-1:0]    round_r, round_upd_s, pass_upd_s;
  logic [FW-1:0]    fault_upd_s;
  logic             result_ok_r;
  logic [WIDTH-1:0] exp_s;
  logic             qv_s, busy_s, done_s, override_s;

  challenge_lfsr #(.WIDTH(WIDTH), .POLY(POLY), .SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset   (reset),
    .advance (state_r == ST_CHECK),
    .q       (question)
  );

  assign exp_s = WIDTH'(expected_answer(MAX_WIDTH'(question)));

  // Saturating round/pass/fault updates applied when leaving CHECK
  always_comb begin
    pass_upd_s  = pass_count;
    fault_upd_s = fault_count;
    round_upd_s = round_r;
    if (result_ok_r) begin
      if (pass_count != ROUNDS_P) pass_upd_s = pass_count + PW'(1);
      else                        pass_upd_s = pass_count;
    end else begin
      if (fault_count != FAULT_MAX) fault_upd_s = fault_count + FW'(1);
      else                          fault_upd_s = fault_count;
    end
    if (round_r != ROUNDS_P) round_upd_s = round_r + PW'(1);
    else                     round_upd_s = round_r;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= ST_IDLE;
    else        state_r <= next_state_s;
  end

  // Next-state logic; an answer on the timeout cycle takes priority
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) next_state_s = ST_WAIT;
        else       next_state_s = ST_IDLE;
      end
      ST_WAIT: begin
        if (answer_valid)             next_state_s = ST_CHECK;
        else if (timer_r == TIMER_LAST) next_state_s = ST_CHECK;
        else                          next_state_s = ST_WAIT;
      end
      ST_CHECK: begin
        if (fault_upd_s == FAULT_MAX)    next_state_s = ST_LOCKOUT;
        else if (round_upd_s == ROUNDS_P) next_state_s = ST_DONE;
        else                             next_state_s = ST_WAIT;
      end
      ST_DONE:    next_state_s = ST_IDLE;
      ST_LOCKOUT: next_state_s = ST_LOCKOUT;
      default:    next_state_s = ST_IDLE;
    endcase
  end

  // Timer, round counter, compare result and session counts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_r     <= '0;
      round_r     <= '0;
      result_ok_r <= 1'b0;
      pass_count  <= '0;
      fault_count <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            timer_r     <= '0;
            round_r     <= '0;
            pass_count  <= '0;
            fault_count <= '0;
          end
        end
        ST_WAIT: begin
          if (answer_valid) begin
            result_ok_r <= (answer == exp_s);
          end else if (timer_r == TIMER_LAST) begin
            result_ok_r <= 1'b0;
          end else begin
            timer_r <= timer_r + TW'(1);
          end
        end
        ST_CHECK: begin
          pass_count  <= pass_upd_s;
          fault_count <= fault_upd_s;
          round_r     <= round_upd_s;
          timer_r     <= '0;
        end
        default: begin
          timer_r <= timer_r;
        end
      endcase
    end
  end

  // Output decode from the upcoming state so the flags come straight from flops
  always_comb begin
    qv_s       = 1'b0;
    busy_s     = 1'b0;
    done_s     = 1'b0;
    override_s = 1'b0;
    case (next_state_s)
      ST_WAIT:    begin qv_s = 1'b1; busy_s = 1'b1; end
      ST_CHECK:   busy_s     = 1'b1;
      ST_DONE:    done_s     = 1'b1;
      ST_LOCKOUT: override_s = 1'b1;
      default:    busy_s     = 1'b0;
    endcase
  end

  // Output flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      question_valid <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      override       <= 1'b0;
    end else begin
      question_valid <= qv_s;
      busy           <= busy_s;
      done           <= done_s;
      override       <= override_s;
    end
  end

endmodule

// File: tb/tb_challenge_watchdog.sv
// Directed bench for challenge_watchdog: a round-level model drives per-cycle
// expectations for the default instance, plus literal checks on an 8-bit one.
module tb_challenge_watchdog;

  localparam int T  = 8;
  localparam int R  = 10;
  localparam int MF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] answer = 4'h0;
  logic       answer_valid = 1'b0;
  logic [3:0] question;
  logic       question_valid, busy, done, override;
  logic [3:0] pass_count;
  logic [1:0] fault_count;

  logic       start8 = 1'b0;
  logic [7:0] answer8 = 8'h00;
  logic       av8 = 1'b0;
  logic [7:0] question8;
  logic       qv8, busy8, done8, override8;
  logic [1:0] pass8;
  logic [1:0] fault8;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  // model state for the default instance
  logic [3:0] m_q = 4'h1;
  int m_pass = 0, m_fault = 0, m_round = 0;
  bit m_qv = 0, m_busy = 0, m_done = 0, m_ovr = 0;

  always #5 clk = ~clk;

  challenge_watchdog dut (
    .clk(clk), .reset(reset), .start(start), .question(question),
    .question_valid(question_valid), .answer(answer), .answer_valid(answer_valid),
    .busy(busy), .done(done), .override(override),
    .pass_count(pass_count), .fault_count(fault_count)
  );

  challenge_watchdog #(.WIDTH(8), .ROUNDS(3), .POLY(8'hB8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .question(question8),
    .question_valid(qv8), .answer(answer8), .answer_valid(av8),
    .busy(busy8), .done(done8), .override(override8),
    .pass_count(pass8), .fault_count(fault8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [3:0] exp_ans(input logic [3:0] q);
    return q ^ {q[2:0], 1'b0} ^ 4'b0001;
  endfunction

  function automatic logic [3:0] lfsr_next(input logic [3:0] q);
    return (q >> 1) ^ (q[0] ? 4'hC : 4'h0);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_q = 4'h1; m_pass = 0; m_fault = 0; m_round = 0;
    m_qv = 0; m_busy = 0; m_done = 0; m_ovr = 0;
  endtask

  // every cycle: all default-instance outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cycle", {18'd0, question, question_valid, busy, done, override, pass_count, fault_count},
            {18'd0, m_q, m_qv, m_busy, m_done, m_ovr, 4'(m_pass), 2'(m_fault)});
    end
  end

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pass = 0; m_fault = 0; m_round = 0; m_qv = 1; m_busy = 1;
  endtask

  // k = WAIT cycle (1..T) on which the answer is presented, 0 = never
  task automatic do_round(input int k, input logic [3:0] ans);
    bit ok;
    int cyc;
    ok = 1'b0;
    cyc = (k >= 1 && k <= T) ? k : T;
    for (int c = 1; c <= cyc; c++) begin
      if (c == k) begin
        answer = ans;
        answer_valid = 1'b1;
        ok = (ans == exp_ans(m_q));
      end
      tick();
      answer_valid = 1'b0;
    end
    m_qv = 0; m_busy = 1;
    tick();
    if (ok) begin
      if (m_pass < R) m_pass++;
    end else begin
      if (m_fault < MF) m_fault++;
    end
    m_q = lfsr_next(m_q);
    m_round++;
    if (m_fault >= MF) begin
      m_ovr = 1; m_qv = 0; m_busy = 0;
    end else if (m_round == R) begin
      m_done = 1; m_qv = 0; m_busy = 0;
      tick();
      m_done = 0;
    end else begin
      m_qv = 1; m_busy = 1;
    end
  endtask

  task automatic hard_reset();
    reset = 1'b0;
    #1;
    model_reset();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int ks[R];
    logic [3:0] lit_ans[3];
    logic [7:0] lit_q8[3];
    logic [7:0] lit_a8[3];
    ks = '{1, 2, T, 1, 3, 5, 1, 4, 7, 2};
    lit_ans = '{4'h2, 4'h5, 4'hB};
    lit_q8  = '{8'h01, 8'hB8, 8'h5C};
    lit_a8  = '{8'h02, 8'hC9, 8'hE5};

    model_reset();
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    check("reset_question", question, 4'h1);
    check("reset_flags", {question_valid, busy, done, override}, 4'b0000);
    check("reset_counts", {pass_count, fault_count}, 6'd0);

    // session 1: all correct, varied latency incl. the timeout edge
    start_session();
    check("q_round1", question, 4'h1);
    for (int r = 0; r < R; r++) begin
      if (r == 3) start = 1'b1;
      do_round(ks[r], (r < 3) ? lit_ans[r] : exp_ans(m_q));
      start = 1'b0;
      if (r == 0) check("q_round2", question, 4'hC);
      if (r == 1) check("q_round3", question, 4'h6);
      if (r == 2) check("timeout_edge_pass", {pass_count, fault_count}, {4'd3, 2'd0});
    end
    check("s1_pass", pass_count, 4'd10);
    check("s1_fault_ovr", {fault_count, override}, 3'b000);

    // session 2: three wrong answers lock out
    hard_reset();
    start_session();
    for (int r = 0; r < 3; r++) do_round(1, 4'h0);
    check("lock_override", override, 1'b1);
    check("lock_counts", {pass_count, fault_count}, {4'd0, 2'd3});
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    answer = exp_ans(m_q); answer_valid = 1'b1;
    tick();
    answer_valid = 1'b0;
    tick();
    check("lock_sticky", {busy, done, override, question_valid}, 4'b0010);

    // session 3: timeouts only
    hard_reset();
    start_session();
    do_round(0, 4'h0);
    check("timeout_fault1", fault_count, 2'd1);
    do_round(0, 4'h0);
    do_round(0, 4'h0);
    check("timeout_lock", {override, fault_count}, 3'b111);

    // session 4: reset during WAIT of round 5
    hard_reset();
    start_session();
    for (int r = 0; r < 4; r++) do_round(1, exp_ans(m_q));
    tick(); tick();
    reset = 1'b0;
    #1;
    check("midreset_question", question, 4'h1);
    check("midreset_state", {question_valid, busy, pass_count}, 6'd0);
    model_reset();
    tick();
    reset = 1'b1;
    tick();
    start_session();
    check("restart_question", question, 4'h1);
    do_round(1, 4'h2);
    check("restart_pass", pass_count, 4'd1);
    hard_reset();

    // 8-bit instance: IDLE answer ignored, then three correct rounds
    av8 = 1'b1; answer8 = 8'h02;
    tick();
    av8 = 1'b0;
    tick();
    check("w8_idle_ignore", {question8, busy8, 2'(pass8)}, {8'h01, 1'b0, 2'd0});
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("w8_start", {qv8, busy8}, 2'b11);
    for (int r = 0; r < 3; r++) begin
      check("w8_question", question8, lit_q8[r]);
      answer8 = lit_a8[r]; av8 = 1'b1;
      tick();
      av8 = 1'b0;
      check("w8_check", {qv8, busy8}, 2'b01);
      tick();
      if (r < 2) check("w8_pass", {qv8, 2'(pass8)}, {1'b1, 2'(r + 1)});
    end
    check("w8_done", {done8, 2'(pass8), override8}, {1'b1, 2'd3, 1'b0});
    tick();
    check("w8_done_end", {done8, busy8}, 2'b00);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
